pe_context_seq: RTL and testbench

- Per-PE context sequencer and writeback stage. It is the driving and retiring end of the combinational FU interface.
- Holds a small context memory loaded by the array configuration bus. Steps through the contexts once per cycle for a programmed number of iterations.
- Drives op_mode, operands, imm and predicate into the FU. Retires the FU results (outvalue, outpred, write_back, write_back_p) into a local register file, a predicate register and a registered PE output.

---
 rtl/pe_pkg.sv | 73 +++++++
 rtl/pe_ctx_mem.sv | 35 +++
 rtl/pe_context_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_pe_context_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg
//   Shared definitions for the PE context sequencer:
//   - bit offsets and widths of the fields inside a 32-bit context word
//   - operand source codes (register file, neighbours, PE output, zero)
//   - the FU nop opcode
//   - sequencer FSM state encoding
//   - a decode helper that unpacks a raw context word into a struct
package pe_pkg;

  // Context word layout
  localparam int OP_LSB        = 0;
  localparam int OP_W          = 8;
  localparam int F_SRC_LSB     = 8;
  localparam int S_SRC_LSB     = 11;
  localparam int SRC_W         = 3;
  localparam int IMM_BIT       = 14;
  localparam int IMM_VAL_LSB   = 15;
  localparam int IMM_VAL_W     = 8;
  localparam int DST_LSB       = 23;
  localparam int DST_W         = 2;
  localparam int PRED_CTRL_BIT = 25;
  localparam int OUT_EN_BIT    = 26;
  localparam int RSVD_LSB      = 27;
  localparam int RSVD_W        = 5;

  // Operand source codes
  localparam logic [SRC_W-1:0] SRC_R0   = 3'd0;
  localparam logic [SRC_W-1:0] SRC_R1   = 3'd1;
  localparam logic [SRC_W-1:0] SRC_R2   = 3'd2;
  localparam logic [SRC_W-1:0] SRC_R3   = 3'd3;
  localparam logic [SRC_W-1:0] SRC_IN_A = 3'd4;
  localparam logic [SRC_W-1:0] SRC_IN_B = 3'd5;
  localparam logic [SRC_W-1:0] SRC_OUT  = 3'd6;
  localparam logic [SRC_W-1:0] SRC_ZERO = 3'd7;

  // Opcode the FU treats as "do nothing, assert no write enables"
  localparam logic [OP_W-1:0] OP_NOP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [RSVD_W-1:0]    rsvd;
    logic                 out_en;
    logic                 pred_control;
    logic [DST_W-1:0]     dst;
    logic [IMM_VAL_W-1:0] imm_val;
    logic                 imm;
    logic [SRC_W-1:0]     s_src;
    logic [SRC_W-1:0]     f_src;
    logic [OP_W-1:0]      op_mode;
  } ctx_t;

  // Field-by-field unpack using the offsets above, so the layout lives in
  // one place even if the struct ordering is ever changed.
  function automatic ctx_t decode_ctx(input logic [31:0] w);
    ctx_t d;
    d.op_mode      = w[OP_LSB      +: OP_W];
    d.f_src        = w[F_SRC_LSB   +: SRC_W];
    d.s_src        = w[S_SRC_LSB   +: SRC_W];
    d.imm          = w[IMM_BIT];
    d.imm_val      = w[IMM_VAL_LSB +: IMM_VAL_W];
    d.dst          = w[DST_LSB     +: DST_W];
    d.pred_control = w[PRED_CTRL_BIT];
    d.out_en       = w[OUT_EN_BIT];
    d.rsvd         = w[RSVD_LSB    +: RSVD_W];
    return d;
  endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// pe_ctx_mem
//   DEPTH x 32 context memory with one synchronous write port and one
//   asynchronous (combinational) read port. Contents are intentionally not
//   reset, so a program survives a sequencer reset.
// Ports:
//   clk    - clock
//   we     - write enable (already qualified by the caller)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, valid in the same cycle as raddr
module pe_ctx_mem #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port: no reset on purpose, the array is a plain storage block.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_context_seq.sv
// pe_context_seq
//   Per-PE context sequencer and writeback stage. Steps through a small
//   context memory once per cycle for a programmed number of iterations,
//   drives the decoded context onto the combinational FU interface and
//   retires the FU results into R0-R3, the predicate register and the
//   registered PE output.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cfg_we/addr/data  - context memory write port, honoured only in IDLE
//   cfg_ready         - high while IDLE (context writes accepted)
//   start             - launch pulse, sampled in IDLE
//   ctx_len, iter_cnt - program length and iteration count, latched at start
//   stall             - freezes sequencing and every architectural write
//   in_a, in_b        - neighbour operands
//   busy, done        - RUN indicator, one-cycle completion pulse
//   out_data/out_valid- registered PE output and its update pulse
//   fu_*              - outgoing context fields / incoming FU results
module pe_context_seq
  import pe_pkg::*;
#(
  parameter int CTX_DEPTH = 16,
  parameter int ITER_W    = 16,
  localparam int CA       = $clog2(CTX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CA-1:0]     cfg_addr,
  input  logic [31:0]       cfg_data,
  output logic              cfg_ready,
  input  logic              start,
  input  logic [CA:0]       ctx_len,
  input  logic [ITER_W-1:0] iter_cnt,
  input  logic              stall,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  output logic              busy,
  output logic              done,
  output logic [31:0]       out_data,
  output logic              out_valid,
  output logic [7:0]        fu_op_mode,
  output logic [31:0]       fu_f_value,
  output logic [31:0]       fu_s_value,
  output logic              fu_imm,
  output logic [7:0]        fu_imm_val,
  output logic              fu_pred_control,
  output logic [3:0]        fu_pred,
  input  logic [31:0]       fu_outvalue,
  input  logic [3:0]        fu_outpred,
  input  logic              fu_write_back,
  input  logic              fu_write_back_p
);

  localparam logic [CA:0]       LEN_MAX  = (CA+1)'(CTX_DEPTH);
  localparam logic [CA:0]       LEN_ONE  = (CA+1)'(1);
  localparam logic [CA-1:0]     PC_ONE   = CA'(1);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  state_t            state;
  state_t            state_n;
  logic [CA-1:0]     pc;
  logic [CA:0]       len;
  logic [ITER_W-1:0] iter;
  logic [31:0]       regs [4];
  logic [3:0]        pred;

  logic [31:0]       ctx_word;
  ctx_t              ctx;
  logic              last_ctx;
  logic              active;
  logic              retire;
  logic              unused_rsvd;

  // Operand selection shared by both FU operand ports.
  function automatic logic [31:0] src_mux(
    input logic [2:0]  src,
    input logic [31:0] r0,
    input logic [31:0] r1,
    input logic [31:0] r2,
    input logic [31:0] r3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] o
  );
    case (src)
      SRC_R0:   return r0;
      SRC_R1:   return r1;
      SRC_R2:   return r2;
      SRC_R3:   return r3;
      SRC_IN_A: return a;
      SRC_IN_B: return b;
      SRC_OUT:  return o;
      default:  return 32'd0;
    endcase
  endfunction

  pe_ctx_mem #(
    .DEPTH (CTX_DEPTH)
  ) u_ctx_mem (
    .clk   (clk),
    .we    (cfg_we && cfg_ready),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (pc),
    .rdata (ctx_word)
  );

  assign ctx         = decode_ctx(ctx_word);
  assign unused_rsvd = ^ctx.rsvd;

  assign last_ctx  = ({1'b0, pc} == (len - LEN_ONE));
  // The FU interface is only live in RUN; a reset cycle forces it quiet
  // even though the state register has not yet returned to IDLE.
  assign active    = (state == RUN) && !rst;
  assign retire    = (state == RUN) && !stall;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  // Next-state logic. A zero length or zero iteration count skips straight
  // to DONE so the caller still sees a completion pulse.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ((ctx_len != '0) && (iter_cnt != '0)) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!stall && last_ctx && (iter <= ITER_ONE)) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus program counter / iteration bookkeeping.
  // The length is clamped to the memory depth so pc can always reach len-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      len   <= '0;
      iter  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            pc   <= '0;
            len  <= (ctx_len > LEN_MAX) ? LEN_MAX : ctx_len;
            iter <= iter_cnt;
          end
        end
        RUN: begin
          if (!stall) begin
            if (last_ctx) begin
              pc   <= '0;
              iter <= iter - ITER_ONE;
            end else begin
              pc   <= pc + PC_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Writeback of FU results. Register reads happen combinationally from the
  // current values, so a context that reads and writes the same register
  // sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      pred      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (retire) begin
        if (fu_write_back) begin
          regs[ctx.dst] <= fu_outvalue;
          if (ctx.out_en) begin
            out_data  <= fu_outvalue;
            out_valid <= 1'b1;
          end
        end
        if (fu_write_back_p) begin
          pred <= fu_outpred;
        end
      end
    end
  end

  // FU drive: decoded current context while active, nop otherwise.
  always_comb begin
    fu_op_mode      = OP_NOP;
    fu_f_value      = '0;
    fu_s_value      = '0;
    fu_imm          = 1'b0;
    fu_imm_val      = '0;
    fu_pred_control = 1'b0;
    fu_pred         = '0;
    if (active) begin
      fu_op_mode      = ctx.op_mode;
      fu_f_value      = src_mux(ctx.f_src, regs[0], regs[1], regs[2], regs[3],
                                in_a, in_b, out_data);
      fu_s_value      = src_mux(ctx.s_src, regs[0], regs[1], regs[2], regs[3],
                                in_a, in_b, out_data);
      fu_imm          = ctx.imm;
      fu_imm_val      = ctx.imm_val;
      fu_pred_control = ctx.pred_control;
      fu_pred         = pred;
    end
  end

endmodule

// File: tb/tb_pe_context_seq.sv
module tb_pe_context_seq;
  import pe_pkg::*;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_ready;
  logic        start;
  logic [4:0]  ctx_len;
  logic [15:0] iter_cnt;
  logic        stall;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_valid;
  logic [7:0]  fu_op_mode;
  logic [31:0] fu_f_value;
  logic [31:0] fu_s_value;
  logic        fu_imm;
  logic [7:0]  fu_imm_val;
  logic        fu_pred_control;
  logic [3:0]  fu_pred;
  logic [31:0] fu_outvalue;
  logic [3:0]  fu_outpred;
  logic        fu_write_back;
  logic        fu_write_back_p;
  logic [31:0] fu_operand2;

  int checks = 0;
  int errors = 0;

  pe_context_seq #(
    .CTX_DEPTH (16),
    .ITER_W    (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .cfg_ready       (cfg_ready),
    .start           (start),
    .ctx_len         (ctx_len),
    .iter_cnt        (iter_cnt),
    .stall           (stall),
    .in_a            (in_a),
    .in_b            (in_b),
    .busy            (busy),
    .done            (done),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .fu_op_mode      (fu_op_mode),
    .fu_f_value      (fu_f_value),
    .fu_s_value      (fu_s_value),
    .fu_imm          (fu_imm),
    .fu_imm_val      (fu_imm_val),
    .fu_pred_control (fu_pred_control),
    .fu_pred         (fu_pred),
    .fu_outvalue     (fu_outvalue),
    .fu_outpred      (fu_outpred),
    .fu_write_back   (fu_write_back),
    .fu_write_back_p (fu_write_back_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal FU: op 0x00 = add (predicated on pred[0] when pred_control),
  // op 0x20 = compare-equal into the predicate, anything else = nop.
  always_comb begin
    fu_outvalue     = '0;
    fu_outpred      = '0;
    fu_write_back   = 1'b0;
    fu_write_back_p = 1'b0;
    fu_operand2     = fu_imm ? {24'd0, fu_imm_val} : fu_s_value;
    case (fu_op_mode)
      8'h00: begin
        fu_outvalue   = fu_f_value + fu_operand2;
        fu_write_back = !fu_pred_control || fu_pred[0];
      end
      8'h20: begin
        fu_outpred      = (fu_f_value == fu_operand2) ? 4'h1 : 4'h0;
        fu_write_back_p = 1'b1;
      end
      default: ;
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mkCtx(input logic [7:0] op, input logic [2:0] fs,
                                        input logic [2:0] ss, input logic imm,
                                        input logic [7:0] iv, input logic [1:0] dst,
                                        input logic pc, input logic oe);
    return {5'b0, oe, pc, dst, iv, imm, ss, fs, op};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic writeCtx(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Launches a program and watches it to completion (bounded). Optionally
  // stalls for stall_len cycles starting stall_at cycles into RUN, checking
  // that the held context still shows stall_f on the first operand, and
  // optionally tries a context write in the first RUN cycle.
  task automatic applyStimulus(input logic [4:0] len, input logic [15:0] it,
                               input int stall_at, input int stall_len,
                               input logic [31:0] stall_f, input bit cfg_poke,
                               output int busy_n, output int done_n,
                               output int valid_n, output logic [7:0] first_op);
    @(negedge clk);
    ctx_len  = len;
    iter_cnt = it;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    first_op = fu_op_mode;
    busy_n   = 0;
    done_n   = 0;
    valid_n  = 0;
    for (int c = 0; c < 200; c++) begin
      stall = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
      if (cfg_poke) begin
        cfg_we   = (c == 0);
        cfg_addr = 4'd0;
        cfg_data = mkCtx(8'h00, SRC_IN_A, SRC_ZERO, 1'b1, 8'd99, 2'd0, 1'b0, 1'b1);
      end
      if (stall) checkOutput("stall_hold_f", fu_f_value, stall_f);
      if (busy) busy_n++;
      if (out_valid) valid_n++;
      if (done) begin
        done_n++;
        break;
      end
      @(negedge clk);
    end
    stall  = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic readReg(input logic [1:0] r, output logic [31:0] val);
    int b, d, v;
    logic [7:0] op;
    writeCtx(4'd0, mkCtx(8'h00, {1'b0, r}, SRC_ZERO, 1'b1, 8'd0, r, 1'b0, 1'b1));
    applyStimulus(5'd1, 16'd1, 0, 0, 32'd0, 1'b0, b, d, v, op);
    val = out_data;
  endtask

  task automatic loadChain();
    writeCtx(4'd0, mkCtx(8'h00, SRC_IN_A, SRC_ZERO, 1'b1, 8'd3, 2'd0, 1'b0, 1'b0));
    writeCtx(4'd1, mkCtx(8'h00, SRC_R0,   SRC_ZERO, 1'b1, 8'd1, 2'd1, 1'b0, 1'b0));
    writeCtx(4'd2, mkCtx(8'h00, SRC_R1,   SRC_IN_B, 1'b0, 8'd0, 2'd2, 1'b0, 1'b0));
    writeCtx(4'd3, mkCtx(8'h00, SRC_R2,   SRC_R0,   1'b0, 8'd0, 2'd3, 1'b0, 1'b1));
  endtask

  initial begin
    int busy_n, done_n, valid_n;
    logic [7:0]  first_op;
    logic [31:0] rv;
    logic [31:0] chain_exp [4];
    logic        seen_done;

    chain_exp[0] = 32'd13;
    chain_exp[1] = 32'd14;
    chain_exp[2] = 32'd114;
    chain_exp[3] = 32'd127;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    ctx_len = '0; iter_cnt = '0; stall = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_op_mode", {24'd0, fu_op_mode}, 32'hFF);
    checkOutput("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    checkOutput("rst_fu_pred", {28'd0, fu_pred}, 32'd0);

    // Single context: out = in_a + 5
    in_a = 32'd10;
    writeCtx(4'd0, mkCtx(8'h00, SRC_IN_A, SRC_ZERO, 1'b1, 8'd5, 2'd0, 1'b0, 1'b1));
    applyStimulus(5'd1, 16'd1, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("single_op_mode", {24'd0, first_op}, 32'd0);
    checkOutput("single_out_data", out_data, 32'd15);
    checkOutput("single_valid_cnt", 32'(valid_n), 32'd1);
    checkOutput("single_done_cnt", 32'(done_n), 32'd1);
    checkOutput("single_busy_cnt", 32'(busy_n), 32'd1);
    checkOutput("single_done_low", {31'd0, done}, 32'd0);
    checkOutput("single_idle", {31'd0, cfg_ready}, 32'd1);

    // Loop: R1 = R1 + 1, four iterations
    writeCtx(4'd0, mkCtx(8'h00, SRC_R1, SRC_ZERO, 1'b1, 8'd1, 2'd1, 1'b0, 1'b1));
    applyStimulus(5'd1, 16'd4, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("loop_busy_cnt", 32'(busy_n), 32'd4);
    checkOutput("loop_valid_cnt", 32'(valid_n), 32'd4);
    checkOutput("loop_out_data", out_data, 32'd4);
    readReg(2'd1, rv);
    checkOutput("loop_r1", rv, 32'd4);

    // Predication: cmp R0==0, then predicated add of in_a+7
    doReset();
    in_a = 32'd10;
    writeCtx(4'd0, mkCtx(8'h20, SRC_R0,   SRC_ZERO, 1'b1, 8'd0, 2'd0, 1'b0, 1'b0));
    writeCtx(4'd1, mkCtx(8'h00, SRC_IN_A, SRC_ZERO, 1'b1, 8'd7, 2'd2, 1'b1, 1'b1));
    applyStimulus(5'd2, 16'd1, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("pred_true_out", out_data, 32'd17);
    checkOutput("pred_true_valid", 32'(valid_n), 32'd1);
    checkOutput("pred_true_busy", 32'(busy_n), 32'd2);
    writeCtx(4'd0, mkCtx(8'h00, SRC_ZERO, SRC_ZERO, 1'b1, 8'd3, 2'd0, 1'b0, 1'b0));
    applyStimulus(5'd1, 16'd1, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("set_r0_no_out", out_data, 32'd17);
    writeCtx(4'd0, mkCtx(8'h20, SRC_R0, SRC_ZERO, 1'b1, 8'd0, 2'd0, 1'b0, 1'b0));
    in_a = 32'd20;
    applyStimulus(5'd2, 16'd1, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("pred_false_out", out_data, 32'd17);
    checkOutput("pred_false_valid", 32'(valid_n), 32'd0);

    // Four-context chain, unstalled then stalled for three cycles
    doReset();
    in_a = 32'd10;
    in_b = 32'd100;
    loadChain();
    applyStimulus(5'd4, 16'd1, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("chain_busy", 32'(busy_n), 32'd4);
    checkOutput("chain_out", out_data, 32'd127);
    for (int r = 0; r < 4; r++) begin
      readReg(2'(r), rv);
      checkOutput($sformatf("chain_r%0d", r), rv, chain_exp[r]);
    end
    doReset();
    loadChain();
    applyStimulus(5'd4, 16'd1, 1, 3, 32'd13, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("stall_busy", 32'(busy_n), 32'd7);
    checkOutput("stall_valid", 32'(valid_n), 32'd1);
    checkOutput("stall_out", out_data, 32'd127);
    for (int r = 0; r < 4; r++) begin
      readReg(2'(r), rv);
      checkOutput($sformatf("stall_r%0d", r), rv, chain_exp[r]);
    end

    // Zero iteration / zero length: immediate done, nothing retires
    writeCtx(4'd0, mkCtx(8'h00, SRC_IN_A, SRC_ZERO, 1'b1, 8'd5, 2'd0, 1'b0, 1'b1));
    applyStimulus(5'd1, 16'd0, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("iter0_done", 32'(done_n), 32'd1);
    checkOutput("iter0_busy", 32'(busy_n), 32'd0);
    checkOutput("iter0_op_mode", {24'd0, first_op}, 32'hFF);
    checkOutput("iter0_valid", 32'(valid_n), 32'd0);
    checkOutput("iter0_out", out_data, 32'd127);
    applyStimulus(5'd0, 16'd5, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("len0_done", 32'(done_n), 32'd1);
    checkOutput("len0_busy", 32'(busy_n), 32'd0);

    // Context write during RUN is dropped
    in_a = 32'd10;
    applyStimulus(5'd1, 16'd3, 0, 0, 32'd0, 1'b1, busy_n, done_n, valid_n, first_op);
    checkOutput("poke_busy", 32'(busy_n), 32'd3);
    checkOutput("poke_out", out_data, 32'd15);
    in_a = 32'd30;
    applyStimulus(5'd1, 16'd1, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("poke_rerun_out", out_data, 32'd35);

    // Reset in the middle of a long loop
    writeCtx(4'd0, mkCtx(8'h00, SRC_R1, SRC_ZERO, 1'b1, 8'd1, 2'd1, 1'b0, 1'b1));
    doReset();
    @(negedge clk);
    ctx_len  = 5'd1;
    iter_cnt = 16'd100;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midrst_busy_before", {31'd0, busy}, 32'd1);
    checkOutput("midrst_out_before", out_data, 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("midrst_op_nop", {24'd0, fu_op_mode}, 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_out", out_data, 32'd0);
    checkOutput("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    seen_done = done;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    checkOutput("midrst_no_done", {31'd0, seen_done}, 32'd0);
    applyStimulus(5'd1, 16'd2, 0, 0, 32'd0, 1'b0, busy_n, done_n, valid_n, first_op);
    checkOutput("midrst_rerun_out", out_data, 32'd2);
    checkOutput("midrst_rerun_done", 32'(done_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
